// File: rtl/text_row_buffer.sv
// -----------------------------------------------------------------------------
// text_row_buffer
//
// Writable multi-row character buffer for the OLED text path. The display
// logic reads characters by address with one cycle of latency; producers
// write characters and control commands through a valid/ready port.
// Writing past the last cell, or a newline on the last row, scrolls the
// whole screen up one row and blanks the bottom row.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   readAddress  display read address (ADDRESS_OFFSET maps to cell 0)
//   outByte      character at readAddress, registered (1 cycle latency)
//   wr_valid     command valid
//   wr_ready     command accepted this cycle when wr_valid=1
//   wr_cmd       00 PUT, 01 SET_CURSOR, 10 CLEAR, 11 NEWLINE
//   wr_data      character for PUT
//   wr_addr      target for SET_CURSOR (ADDRESS_OFFSET applied)
//   cursor       current cell index, 0..N-1
//   busy         CLEAR or SCROLL sweep in progress (equals !wr_ready)
// -----------------------------------------------------------------------------
module text_row_buffer #(
  parameter int                ADDR_W         = 8,
  parameter int                COLS           = 16,
  parameter int                ROWS           = 4,
  parameter logic [ADDR_W-1:0] ADDRESS_OFFSET = '0,
  parameter logic [7:0]        FILL_CHAR      = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readAddress,
  output logic [7:0]        outByte,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_cmd,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  localparam int N     = COLS * ROWS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Range limit for address checks, one bit wider so N = 2^ADDR_W still works.
  localparam logic [ADDR_W:0]   N_EXT       = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(N - 1);
  // First cell of the bottom row; also the number of cells moved by a scroll.
  localparam logic [ADDR_W-1:0] SCROLL_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [IDX_W-1:0]  COLS_I      = IDX_W'(COLS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_SET     = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_NEWLINE = 2'b11;

  // Character store: single write port, combinational reads.
  logic [7:0] mem_q [N];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [7:0]        out_q, out_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [7:0]        mem_wd;

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_hit;
  logic [ADDR_W-1:0] set_idx;
  logic              set_hit;
  logic [ADDR_W-1:0] next_row_start;
  logic [IDX_W-1:0]  scroll_src;
  logic              sweep_last;

  assign wr_ready = (state_q == ST_IDLE);
  assign busy     = !wr_ready;
  assign cursor   = cursor_q;
  assign outByte  = out_q;

  // Offset removal wraps modulo 2^ADDR_W, so addresses below the offset
  // become large and fall out of range.
  assign rd_idx  = readAddress - ADDRESS_OFFSET;
  assign rd_hit  = ({1'b0, rd_idx} < N_EXT);
  assign set_idx = wr_addr - ADDRESS_OFFSET;
  assign set_hit = ({1'b0, set_idx} < N_EXT);

  assign next_row_start = ((cursor_q / COLS_A) + 1'b1) * COLS_A;

  // Source cell one row below the sweep position. Only meaningful while
  // k_q < SCROLL_BASE; beyond that the fill character is selected instead.
  assign scroll_src = k_q[IDX_W-1:0] + COLS_I;
  assign sweep_last = (k_q == LAST_CELL);

  // ---------------------------------------------------------------------------
  // Next-state logic: command execution and sweep sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cursor_d = cursor_q;
    mem_we   = 1'b0;
    mem_wa   = k_q[IDX_W-1:0];
    mem_wd   = FILL_CHAR;

    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          case (wr_cmd)
            CMD_PUT: begin
              mem_we = 1'b1;
              mem_wa = cursor_q[IDX_W-1:0];
              mem_wd = wr_data;
              if (cursor_q == LAST_CELL) begin
                cursor_d = SCROLL_BASE;
                state_d  = ST_SCROLL;
                k_d      = '0;
              end else begin
                cursor_d = cursor_q + 1'b1;
              end
            end
            CMD_SET: begin
              // Out-of-range targets are silently dropped.
              if (set_hit) begin
                cursor_d = set_idx;
              end
            end
            CMD_CLEAR: begin
              cursor_d = '0;
              state_d  = ST_CLEAR;
              k_d      = '0;
            end
            default: begin // CMD_NEWLINE
              if (cursor_q >= SCROLL_BASE) begin
                cursor_d = SCROLL_BASE;
                state_d  = ST_SCROLL;
                k_d      = '0;
              end else begin
                cursor_d = next_row_start;
              end
            end
          endcase
        end
      end

      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wd = FILL_CHAR;
        if (sweep_last) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_SCROLL: begin
        mem_we = 1'b1;
        mem_wd = (k_q < SCROLL_BASE) ? mem_q[scroll_src] : FILL_CHAR;
        if (sweep_last) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover through a full clear.
        state_d = ST_CLEAR;
        k_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path: one-cycle registered lookup, zero outside the buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d = 8'h00;
    if (rd_hit) begin
      out_d = mem_q[rd_idx[IDX_W-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset lands in CLEAR so the array is initialised by the
  // normal sweep rather than by resetting every cell.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      k_q      <= '0;
      cursor_q <= '0;
      out_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cursor_q <= cursor_d;
      out_q    <= out_d;
    end
  end

  // Array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_text_row_buffer.sv
module tb_text_row_buffer;

  localparam logic [1:0] C_PUT = 2'b00;
  localparam logic [1:0] C_SET = 2'b01;
  localparam logic [1:0] C_CLR = 2'b10;
  localparam logic [1:0] C_NL  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] readAddress, readAddress_off;
  logic [7:0] outByte, outByte_off;
  logic       wr_valid;
  logic       wr_ready, wr_ready_off;
  logic [1:0] wr_cmd;
  logic [7:0] wr_data;
  logic [7:0] wr_addr, wr_addr_off;
  logic [7:0] cursor, cursor_off;
  logic       busy, busy_off;

  always #5 clk = ~clk;

  // The offset instance receives the same commands with its SET_CURSOR
  // target shifted, so both instances hold identical contents.
  assign wr_addr_off = wr_addr + 8'd10;

  text_row_buffer #(.ADDR_W(8), .COLS(16), .ROWS(4),
                    .ADDRESS_OFFSET(8'd0), .FILL_CHAR(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .readAddress(readAddress), .outByte(outByte),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_cmd(wr_cmd),
    .wr_data(wr_data), .wr_addr(wr_addr), .cursor(cursor), .busy(busy));

  text_row_buffer #(.ADDR_W(8), .COLS(16), .ROWS(4),
                    .ADDRESS_OFFSET(8'd10), .FILL_CHAR(8'h00)) u_off (
    .clk(clk), .rst_n(rst_n), .readAddress(readAddress_off), .outByte(outByte_off),
    .wr_valid(wr_valid), .wr_ready(wr_ready_off), .wr_cmd(wr_cmd),
    .wr_data(wr_data), .wr_addr(wr_addr_off), .cursor(cursor_off), .busy(busy_off));

  typedef struct {
    bit         sel;
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_item_t;

  rd_item_t rd_q[$];
  logic     rd_req;
  int       errors = 0;
  int       checks = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: a read strobe seen at a clock edge means outByte carries the
  // answer after that edge; compare it with the oldest queued expectation.
  initial begin
    bit       pend;
    rd_item_t it;
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_underflow: read data with no expectation queued");
        end else begin
          it = rd_q.pop_front();
          if (it.sel)
            check8($sformatf("rd_off[%0d]", it.addr), outByte_off, it.exp);
          else
            check8($sformatf("rd[%0d]", it.addr), outByte, it.exp);
        end
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    rd_item_t it;
    it.sel = 1'b0; it.addr = a; it.exp = e;
    readAddress = a;
    rd_req = 1'b1;
    rd_q.push_back(it);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic rd_off(input logic [7:0] a, input logic [7:0] e);
    rd_item_t it;
    it.sel = 1'b1; it.addr = a; it.exp = e;
    readAddress_off = a;
    rd_req = 1'b1;
    rd_q.push_back(it);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  // Presents a command and holds it until accepted; returns cycles held off.
  task automatic cmd(input logic [1:0] c, input logic [7:0] d, input logic [7:0] a,
                     output int waited);
    wr_valid = 1'b1;
    wr_cmd   = c;
    wr_data  = d;
    wr_addr  = a;
    waited   = 0;
    while (!wr_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!wr_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd %0d never accepted", c);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int w;

  initial begin
    rst_n = 1'b0;
    readAddress = 8'd0;
    readAddress_off = 8'd0;
    wr_valid = 1'b0;
    wr_cmd = C_PUT;
    wr_data = 8'h00;
    wr_addr = 8'h00;
    rd_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check8("rst_busy", {7'b0, busy}, 8'h01);
    check8("rst_ready", {7'b0, wr_ready}, 8'h00);
    check8("rst_cursor", cursor, 8'h00);
    check8("rst_outByte", outByte, 8'h00);
    rst_n = 1'b1;
    wait_idle(w);
    check_int("init_clear_cycles", w, 64);
    check8("init_cursor", cursor, 8'h00);
    for (int i = 0; i <= 64; i++) rd(8'(i), 8'h00);
    rd(8'd255, 8'h00);

    // PUT "H", "i"
    cmd(C_PUT, 8'h48, 8'h00, w);
    cmd(C_PUT, 8'h69, 8'h00, w);
    check8("cursor_after_Hi", cursor, 8'd2);
    rd(8'd0, 8'h48);
    rd(8'd1, 8'h69);
    rd(8'd2, 8'h00);
    rd_off(8'd10, 8'h48);
    rd_off(8'd11, 8'h69);
    rd_off(8'd9, 8'h00);
    rd_off(8'd74, 8'h00);

    // SET_CURSOR in and out of range
    cmd(C_SET, 8'h00, 8'd17, w);
    check8("cursor_set17", cursor, 8'd17);
    cmd(C_PUT, 8'h41, 8'h00, w);
    check8("cursor_after_A", cursor, 8'd18);
    rd(8'd17, 8'h41);
    cmd(C_SET, 8'h00, 8'd200, w);
    check8("cursor_set200_ignored", cursor, 8'd18);
    cmd(C_SET, 8'h00, 8'd64, w);
    check8("cursor_set64_ignored", cursor, 8'd18);
    cmd(C_SET, 8'h00, 8'd63, w);
    check8("cursor_set63", cursor, 8'd63);

    // Fill all cells; the 64th PUT triggers a scroll
    cmd(C_SET, 8'h00, 8'd0, w);
    for (int i = 0; i < 64; i++) cmd(C_PUT, 8'(8'h20 + i), 8'h00, w);
    check8("fill_busy", {7'b0, busy}, 8'h01);
    wait_idle(w);
    check_int("fill_scroll_cycles", w, 64);
    check8("cursor_after_fill", cursor, 8'd48);
    rd(8'd0, 8'h30);
    rd(8'd16, 8'h40);
    rd(8'd47, 8'h5F);
    for (int i = 48; i < 64; i++) rd(8'(i), 8'h00);
    rd_off(8'd10, 8'h30);
    rd_off(8'd57, 8'h5F);
    rd_off(8'd58, 8'h00);

    // NEWLINE on the last row, with a PUT held off during the sweep
    cmd(C_SET, 8'h00, 8'd50, w);
    cmd(C_NL, 8'h00, 8'h00, w);
    check_int("nl_scroll_wait", w, 0);
    check8("cursor_nl_last", cursor, 8'd48);
    check8("nl_busy", {7'b0, busy}, 8'h01);
    cmd(C_PUT, 8'h58, 8'h00, w);
    check_int("put_held_cycles", w, 64);
    check8("cursor_after_X", cursor, 8'd49);
    rd(8'd0, 8'h40);
    rd(8'd15, 8'h4F);
    rd(8'd16, 8'h50);
    rd(8'd31, 8'h5F);
    rd(8'd32, 8'h00);
    rd(8'd47, 8'h00);
    rd(8'd48, 8'h58);
    rd(8'd49, 8'h00);

    // NEWLINE mid-screen: no scroll
    cmd(C_SET, 8'h00, 8'd5, w);
    cmd(C_NL, 8'h00, 8'h00, w);
    check8("cursor_nl_row0", cursor, 8'd16);
    check8("nl_row0_busy", {7'b0, busy}, 8'h00);

    // Reset during a scroll, sweep cycle 20
    readAddress = 8'd0;
    cmd(C_SET, 8'h00, 8'd60, w);
    cmd(C_NL, 8'h00, 8'h00, w);
    check8("cursor_pre_reset", cursor, 8'd48);
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check8("async_rst_cursor", cursor, 8'h00);
    check8("async_rst_outByte", outByte, 8'h00);
    check8("async_rst_busy", {7'b0, busy}, 8'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle(w);
    check_int("reclear_cycles", w, 64);
    for (int i = 0; i < 64; i++) rd(8'(i), 8'h00);
    rd_off(8'd10, 8'h00);
    rd_off(8'd73, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check_int("rd_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
